// File: rtl/pcie_bf_upload.sv
// Beamforming parameter upload packer: 32-bit word frames -> 512-bit PCIe AXI-stream beats.
// Optional per-frame header beat when PCIE_BF_HDR_EN is defined.
module pcie_bf_upload #(
  parameter int unsigned MAX_WORDS = 132
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic [31:0]  in_data,
  input  logic         in_vld,
  input  logic         in_last,
  output logic         in_rdy,
  output logic [511:0] pcie_data,
  output logic [63:0]  pcie_keep,
  output logic         pcie_valid,
  output logic         pcie_last,
  input  logic         pcie_ready,
  output logic [15:0]  frame_cnt,
  output logic         err_len
);

  typedef enum logic [1:0] {IDLE, PACK, DROP} state_t;

  localparam logic [11:0] MAX_W = 12'(MAX_WORDS);

  state_t       state;
  logic [511:0] acc;
  logic [3:0]   widx;
  logic [11:0]  wcnt;

  logic [511:0] fifo_data [2];
  logic [63:0]  fifo_keep [2];
  logic [1:0]   fifo_last;
  logic         wp, rp;
  logic [1:0]   fifo_cnt;

`ifdef PCIE_BF_HDR_EN
  logic hdr_sent;
`endif

  logic         accept, hit_max, data_push, beat_last, hdr_push, push, pop;
  logic [11:0]  wcnt_n;
  logic [511:0] beat_data, push_data;
  logic [63:0]  beat_keep, push_keep;
  logic         push_last;

  always_comb begin
    if (w_rst)
      in_rdy = 1'b0;
    else if (state == DROP)
      in_rdy = 1'b1;
`ifdef PCIE_BF_HDR_EN
    else if (state == IDLE && !hdr_sent)
      in_rdy = 1'b0;
`endif
    else
      in_rdy = (fifo_cnt < 2'd2);
  end

  assign accept    = in_vld & in_rdy;
  assign wcnt_n    = wcnt + 12'd1;
  assign hit_max   = (wcnt_n == MAX_W);
  assign beat_last = in_last | hit_max;
  assign data_push = accept && (state != DROP) && ((widx == 4'hF) || in_last || hit_max);

`ifdef PCIE_BF_HDR_EN
  assign hdr_push = (state == IDLE) && !hdr_sent && in_vld && (fifo_cnt < 2'd2) && !w_rst;
`else
  assign hdr_push = 1'b0;
`endif

  // Outgoing beat: accumulator with the current word merged at widx; upper words stay zero.
  always_comb begin
    beat_data = acc;
    beat_data[{widx, 5'd0} +: 32] = in_data;
    beat_keep = '0;
    for (int unsigned i = 0; i < 16; i++)
      beat_keep[4*i +: 4] = (i <= 32'(widx)) ? 4'hF : 4'h0;
  end

  always_comb begin
    if (hdr_push) begin
      push_data = {480'd0, 16'hBF5A, frame_cnt};
      push_keep = 64'hFF;
      push_last = 1'b0;
    end else begin
      push_data = beat_data;
      push_keep = beat_keep;
      push_last = beat_last;
    end
  end

  assign push = data_push | hdr_push;
  assign pop  = (fifo_cnt != 2'd0) & pcie_ready;

  assign pcie_valid = (fifo_cnt != 2'd0);
  assign pcie_data  = pcie_valid ? fifo_data[rp] : '0;
  assign pcie_keep  = pcie_valid ? fifo_keep[rp] : '0;
  assign pcie_last  = pcie_valid & fifo_last[rp];

  // Storage carries no reset; the head is masked by pcie_valid instead.
  always_ff @(posedge w_clk) begin
    if (push) begin
      fifo_data[wp] <= push_data;
      fifo_keep[wp] <= push_keep;
      fifo_last[wp] <= push_last;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state     <= IDLE;
      acc       <= '0;
      widx      <= '0;
      wcnt      <= '0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      fifo_cnt  <= '0;
      frame_cnt <= '0;
      err_len   <= 1'b0;
`ifdef PCIE_BF_HDR_EN
      hdr_sent  <= 1'b0;
`endif
    end else begin
      err_len <= 1'b0;
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (data_push && beat_last)
        frame_cnt <= frame_cnt + 16'd1;
`ifdef PCIE_BF_HDR_EN
      if (hdr_push)
        hdr_sent <= 1'b1;
      else if (data_push && beat_last)
        hdr_sent <= 1'b0;
`endif
      if (accept) begin
        if (state == DROP) begin
          if (in_last) state <= IDLE;
        end else begin
          if (data_push) begin
            acc  <= '0;
            widx <= '0;
          end else begin
            acc[{widx, 5'd0} +: 32] <= in_data;
            widx <= widx + 4'd1;
          end
          if (data_push && beat_last) begin
            wcnt <= '0;
            if (in_last) begin
              state <= IDLE;
            end else begin
              state   <= DROP;
              err_len <= 1'b1;
            end
          end else begin
            wcnt  <= wcnt_n;
            state <= PACK;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_bf_upload.sv
// Directed bench for pcie_bf_upload: framing, keep/last, backpressure, forced termination, reset.
module tb_pcie_bf_upload;

  localparam int MAXW = 132;

  logic         w_clk = 1'b0;
  logic         w_rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_vld = 1'b0;
  logic         in_last = 1'b0;
  logic         in_rdy;
  logic [511:0] pcie_data;
  logic [63:0]  pcie_keep;
  logic         pcie_valid;
  logic         pcie_last;
  logic         pcie_ready = 1'b1;
  logic [15:0]  frame_cnt;
  logic         err_len;

  pcie_bf_upload #(.MAX_WORDS(MAXW)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .in_data(in_data), .in_vld(in_vld), .in_last(in_last), .in_rdy(in_rdy),
    .pcie_data(pcie_data), .pcie_keep(pcie_keep), .pcie_valid(pcie_valid),
    .pcie_last(pcie_last), .pcie_ready(pcie_ready),
    .frame_cnt(frame_cnt), .err_len(err_len)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
  } beat_t;

  beat_t        q[$];
  int           checks = 0;
  int           errors = 0;
  int           err_pulses = 0;
  bit           saw_rdy_low = 1'b0;
  logic [576:0] prev_beat = '0;
  logic         prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [576:0] got, input logic [576:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Beat capture, err_len pulse count and AXI hold-stable check under backpressure.
  always @(posedge w_clk) begin
    if (!w_rst) begin
      if (pcie_valid && pcie_ready) q.push_back('{pcie_data, pcie_keep, pcie_last});
      if (err_len) err_pulses++;
      if (prev_stall) chk("hold_stable", {pcie_data, pcie_keep, pcie_last}, prev_beat);
    end
    prev_stall <= pcie_valid && !pcie_ready && !w_rst;
    prev_beat  <= {pcie_data, pcie_keep, pcie_last};
  end

  function automatic logic [31:0] wd(input int f, input int i);
    return {16'(f), 16'(i)};
  endfunction

  function automatic logic [576:0] exp_beat(input int f, input int nexp, input int b);
    logic [511:0] d = '0;
    logic [63:0]  k = '0;
    int nb = (nexp + 15) / 16;
    for (int j = 0; j < 16; j++) begin
      if (16*b + j < nexp) begin
        d[32*j +: 32] = wd(f, 16*b + j);
        k[4*j +: 4]   = 4'hF;
      end
    end
    return {d, k, (b == nb - 1)};
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l);
    int t = 0;
    @(negedge w_clk);
    in_vld = 1'b1; in_data = d; in_last = l;
    while (!in_rdy && t < 300) begin
      @(negedge w_clk);
      t++;
    end
    if (!in_rdy) chk("in_rdy_timeout", 577'(in_rdy), 577'(1));
    @(posedge w_clk);
    #1 in_vld = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n);
    for (int i = 0; i < n; i++) send_word(wd(f, i), i == n - 1);
  endtask

  task automatic check_frame(input int f, input int n, input int q0);
    int nexp = (n > MAXW) ? MAXW : n;
    int nb = (nexp + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      if (q0 + b < q.size())
        chk($sformatf("f%0d_beat%0d", f, b), {q[q0+b].d, q[q0+b].k, q[q0+b].l}, exp_beat(f, nexp, b));
      else
        chk($sformatf("f%0d_beat%0d_missing", f, b), 577'(q.size()), 577'(q0 + b + 1));
    end
  endtask

  task automatic drain();
    repeat (12) @(negedge w_clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge w_clk);
    chk("rst_in_rdy", 577'(in_rdy), 577'(0));
    chk("rst_valid_last", 577'({pcie_valid, pcie_last}), 577'(0));
    chk("rst_data_keep", 577'({pcie_data, pcie_keep}), 577'(0));
    chk("rst_frame_err", 577'({frame_cnt, err_len}), 577'(0));
    w_rst = 1'b0;

`ifdef PCIE_BF_HDR_EN
    @(negedge w_clk);
    send_frame(0, 16);
    send_frame(1, 16);
    drain();
    chk("hdr_nbeats", 577'(q.size()), 577'(4));
    if (q.size() == 4) begin
      chk("hdr0", {q[0].d, q[0].k, q[0].l}, {480'd0, 32'hBF5A0000, 64'hFF, 1'b0});
      check_frame(0, 16, 1);
      chk("hdr1", {q[2].d, q[2].k, q[2].l}, {480'd0, 32'hBF5A0001, 64'hFF, 1'b0});
      check_frame(1, 16, 3);
    end
    chk("hdr_frame_cnt", 577'(frame_cnt), 577'(2));
`else
    @(negedge w_clk);
    chk("post_rst_in_rdy", 577'(in_rdy), 577'(1));

    // 66-word frame
    send_frame(1, 66);
    drain();
    chk("f66_nbeats", 577'(q.size()), 577'(5));
    check_frame(1, 66, 0);
    if (q.size() == 5) begin
      chk("f66_b0_keep", 577'(q[0].k), 577'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("f66_b4_keep_last", 577'({q[4].k, q[4].l}), 577'({64'h00FF, 1'b1}));
      chk("f66_b4_lo", 577'(q[4].d[63:0]), 577'(64'h0001_0041_0001_0040));
    end
    chk("f66_frame_cnt", 577'(frame_cnt), 577'(1));

    // 16-word frame, latency of the completing word
    q.delete();
    for (int i = 0; i < 15; i++) send_word(wd(2, i), 1'b0);
    @(negedge w_clk);
    chk("f16_no_early_valid", 577'(pcie_valid), 577'(0));
    send_word(wd(2, 15), 1'b1);
    @(negedge w_clk);
    chk("f16_latency", 577'({pcie_valid, pcie_last, pcie_keep}), 577'({1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF}));
    drain();
    chk("f16_nbeats", 577'(q.size()), 577'(1));
    check_frame(2, 16, 0);
    chk("f16_frame_cnt", 577'(frame_cnt), 577'(2));

    // 132-word frame with a 40-cycle downstream stall
    q.delete();
    fork
      send_frame(3, 132);
      begin
        repeat (20) @(negedge w_clk);
        pcie_ready = 1'b0;
        repeat (40) begin
          @(negedge w_clk);
          if (!in_rdy) saw_rdy_low = 1'b1;
        end
        pcie_ready = 1'b1;
      end
    join
    drain();
    chk("stall_rdy_low", 577'(saw_rdy_low), 577'(1));
    chk("f132_nbeats", 577'(q.size()), 577'(9));
    check_frame(3, 132, 0);
    if (q.size() == 9) chk("f132_last_keep", 577'({q[8].k, q[8].l}), 577'({64'hFFFF, 1'b1}));
    chk("f132_frame_cnt", 577'(frame_cnt), 577'(3));

    // 140-word frame, forced termination at 132
    q.delete();
    err_pulses = 0;
    send_frame(4, 140);
    drain();
    chk("f140_nbeats", 577'(q.size()), 577'(9));
    check_frame(4, 140, 0);
    chk("f140_err_pulses", 577'(err_pulses), 577'(1));
    chk("f140_frame_cnt", 577'(frame_cnt), 577'(4));
    q.delete();
    send_frame(5, 16);
    drain();
    chk("after_drop_nbeats", 577'(q.size()), 577'(1));
    check_frame(5, 16, 0);
    chk("after_drop_frame_cnt", 577'(frame_cnt), 577'(5));

    // Reset after 20 words of a frame
    q.delete();
    for (int i = 0; i < 20; i++) send_word(wd(6, i), 1'b0);
    @(negedge w_clk);
    w_rst = 1'b1;
    @(negedge w_clk);
    chk("midrst_outputs", 577'({in_rdy, pcie_valid, frame_cnt}), 577'(0));
    @(negedge w_clk);
    w_rst = 1'b0;
    drain();
    chk("midrst_nbeats", 577'(q.size()), 577'(1));
    if (q.size() == 1) chk("midrst_beat0", {q[0].d, q[0].k, q[0].l}, {exp_beat(6, 32, 0)});
    chk("midrst_frame_cnt", 577'(frame_cnt), 577'(0));
    q.delete();
    send_frame(7, 16);
    drain();
    chk("post_rst_nbeats", 577'(q.size()), 577'(1));
    check_frame(7, 16, 0);
    chk("post_rst_frame_cnt", 577'(frame_cnt), 577'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_bf_upload.md
# pcie_bf_upload

Transmit-side packer for the beamforming parameter path. It takes 32-bit parameter/report words in frames on a valid/ready stream, packs 16 words per beat into a 512-bit PCIe AXI-stream and drives keep/last toward the host DMA. It is the upload counterpart of the PCIe parameter download/URAM write path and uses the same word order: word 0 is in bits [31:0] and fills the lowest address first.

## Interface
- MAX_WORDS, 132, maximum words per frame (1..4095); a frame reaching this count is force-terminated.
- w_clk  in  1  clock, all logic single-domain
- w_rst  in  1  reset; synchronous, active-high; clock w_clk
- in_data  in  32  parameter word
- in_vld  in  1  word valid
- in_last  in  1  last word of frame, qualified by in_vld
- in_rdy  out  1  word accepted when in_vld & in_rdy
- pcie_data  out  512  packed beat
- pcie_keep  out  64  byte enables, 4 bits per word, LSB-aligned
- pcie_valid  out  1  beat valid
- pcie_last  out  1  final beat of frame
- pcie_ready  in  1  downstream accept
- frame_cnt  out  16  frames completed, wraps at 16'hFFFF
- err_len  out  1  one-cycle pulse on a forced termination

## Operation
- Packer: 512-bit accumulator plus 4-bit word index `widx`. An accepted word is written to bits [32*widx+31:32*widx], and `widx` increments.
- Beat push: when `widx`==15 or in_last or word count == MAX_WORDS, the beat {data, keep, last} is pushed into a 2-entry output FIFO.
  - keep = (2^(4*(widx+1)))-1.
  - last is set if in_last or the MAX_WORDS limit caused the push.
  - The accumulator and `widx` then clear.
- Word counter: 12 bits, cleared at every frame end.
- FSM states: IDLE, PACK, DROP.
  - IDLE→PACK on the first accepted word.
  - PACK→IDLE on push with in_last.
  - PACK→DROP when the MAX_WORDS push happens without in_last. err_len pulses in that cycle.
  - DROP: in_rdy=1, words are discarded. DROP→IDLE on in_last.
- in_rdy = (fifo_cnt<2) in IDLE/PACK, and 1 in DROP.
  - Words that do not complete a beat are accepted while the FIFO has a slot; this is deliberately conservative.
- Output: the FIFO head drives pcie_*. A pop happens on pcie_valid & pcie_ready. Push and pop in the same cycle are allowed; the count is unchanged.
- frame_cnt increments on the push carrying last.
- Unused pcie_data bits beyond keep are 0.

## Timing
- Reset values:
  - in_rdy=0, pcie_valid=0, pcie_last=0.
  - pcie_data=0, pcie_keep=0.
  - frame_cnt=0, err_len=0.
  - FSM=IDLE, FIFO empty.
  - in_rdy=1 from the first cycle after w_rst deasserts.
- Latency: a word accepted in cycle N that completes a beat gives pcie_valid=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle sustained; 1 beat per 16 cycles with pcie_ready high.
- AXI rule: while pcie_valid=1 and pcie_ready=0, pcie_data/keep/last are held stable.
- FIFO full: in_rdy=0 in the same cycle, computed combinationally from the registered count.
- in_last on the 16th word gives one full beat with last=1. A single-word frame gives keep=64'hF.
- w_rst mid-frame: the partial beat, FIFO contents and FSM are discarded. frame_cnt is cleared and no beat is emitted.

## Configuration
- PCIE_BF_HDR_EN defined:
  - In IDLE with in_vld=1 and FIFO not full, a header beat is pushed while in_rdy is held at 0 for that cycle.
  - Header: pcie_data[15:0]=frame_cnt, [31:16]=16'hBF5A, keep=64'hFF, last=0.
  - The first data word is then accepted from the following cycle.
  - Adds 1 cycle and 1 beat per frame.
- Not defined: no header; frames begin directly with data beats.

## Test plan
- 66-word frame, pcie_ready=1 -> 5 beats; beats 0–3 keep all-ones; beat 4 keep 64'h00FF, last=1, data[63:0]=words 64,65; frame_cnt=1.
- 16-word frame -> exactly 1 beat, keep 64'hFFFF_FFFF_FFFF_FFFF, last=1; valid 1 cycle after the 16th word.
- 132-word frame with pcie_ready low for 40 cycles mid-stream -> in_rdy drops once 2 beats are queued; held beat unchanged; 9 beats total, last keep 64'hFFFF.
- 140-word frame with MAX_WORDS=132 -> 9 beats, last=1 on beat 8 with keep 64'hFFFF; err_len pulses once; 8 words dropped; next frame normal.
- w_rst asserted after 20 words of a frame -> no further beats, frame_cnt=0; the next 16-word frame yields 1 correct beat.
- PCIE_BF_HDR_EN defined, two 16-word frames -> header beats carry data[31:0]=32'hBF5A0000 then 32'hBF5A0001, keep 64'hFF, each followed by 1 data beat.
